// File: rtl/npu_buf_pkg.sv
// Shared constants and types for the NPU activation/weight buffer readers.
package npu_buf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 20480;
  localparam int DIM_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [DIM_W-1:0]  cols;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  stride;
  } tile_desc_t;

  // Widened to 32 bits so that an oversized tile can never wrap back into range.
  function automatic logic [31:0] tile_last_addr(input tile_desc_t d);
    return 32'(d.base) + (32'(d.rows) - 32'd1) * 32'(d.stride) + 32'(d.cols) - 32'd1;
  endfunction

endpackage

// File: rtl/tdp_tile_reader_if.sv
// Command, buffer port-B and output stream signals of the tile reader.
interface tdp_tile_reader_if;
  import npu_buf_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] cfg_base;
  logic [DIM_W-1:0]  cfg_cols;
  logic [DIM_W-1:0]  cfg_rows;
  logic [DIM_W-1:0]  cfg_stride;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, cfg_base, cfg_cols, cfg_rows, cfg_stride, mem_rdata, out_ready,
    output busy, done, err, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, cfg_base, cfg_cols, cfg_rows, cfg_stride, mem_rdata, out_ready,
    input  busy, done, err, mem_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; slot 0 is always the head, so the output comes straight from a flop.
module skid_fifo2
  import npu_buf_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_slot0;
  logic [W-1:0] r_slot1;
  logic [1:0]   r_count;
  logic         w_pop_ok;
  logic         w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
  assign o_head    = r_slot0;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push_ok) r_slot0 <= i_din;
        end
        2'd1: begin
          if (w_push_ok && w_pop_ok) r_slot0 <= i_din;
          else if (w_push_ok)        r_slot1 <= i_din;
        end
        default: begin
          if (w_pop_ok) begin
            r_slot0 <= r_slot1;
            if (w_push_ok) r_slot1 <= i_din;
          end
        end
      endcase
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

endmodule

// File: rtl/tdp_tile_reader.sv
// Read-side tile walker for buffer port B: validates a 2-D tile descriptor, then
// streams its words in row-major order through a two-entry skid FIFO.
module tdp_tile_reader
  import npu_buf_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  tdp_tile_reader_if.master bus
);

  state_e            r_state;
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_rows;
  logic [DIM_W-1:0]  r_stride;
  logic [DIM_W-1:0]  r_col_cnt;
  logic [DIM_W-1:0]  r_row_cnt;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  tile_desc_t        w_cfg;
  logic [31:0]       w_last_addr;
  logic              w_cfg_ok;
  logic              w_col_end;
  logic              w_final;
  logic              w_issue;
  logic              w_pop;
  logic              w_out_valid;
  logic [ADDR_W-1:0] w_next_row;
  logic [DATA_W:0]   w_head;
  logic [1:0]        w_count;

  assign w_cfg = '{base:   bus.cfg_base,
                   cols:   bus.cfg_cols,
                   rows:   bus.cfg_rows,
                   stride: bus.cfg_stride};
  assign w_last_addr = tile_last_addr(w_cfg);
  assign w_cfg_ok    = (bus.cfg_cols != '0) && (bus.cfg_rows != '0) &&
                       (w_last_addr < 32'(DEPTH));

  assign w_col_end  = (r_col_cnt == r_cols - DIM_W'(1));
  assign w_final    = w_col_end && (r_row_cnt == r_rows - DIM_W'(1));
  assign w_next_row = r_row_base + ADDR_W'(r_stride);

  assign w_out_valid = (w_count != 2'd0);
  assign w_pop       = w_out_valid && bus.out_ready;
  // A read may refill the slot freed by a same-cycle pop, so a full FIFO still streams.
  assign w_issue     = (r_state == FETCH) && ((w_count != 2'd2) || w_pop);

  skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_issue),
    .i_pop   (w_pop),
    .i_din   ({bus.mem_rdata, w_final}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.mem_addr  = r_rd_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_head[DATA_W:1];
  assign bus.out_last  = w_head[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cols     <= '0;
      r_rows     <= '0;
      r_stride   <= '0;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_row_base <= '0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_cols   <= bus.cfg_cols;
            r_rows   <= bus.cfg_rows;
            r_stride <= bus.cfg_stride;
            if (w_cfg_ok) begin
              r_col_cnt  <= '0;
              r_row_cnt  <= '0;
              r_row_base <= bus.cfg_base;
              r_rd_addr  <= bus.cfg_base;
              r_busy     <= 1'b1;
              r_state    <= FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_issue) begin
            if (w_final) begin
              r_state <= DRAIN;
            end else if (w_col_end) begin
              r_col_cnt  <= '0;
              r_row_cnt  <= r_row_cnt + DIM_W'(1);
              r_row_base <= w_next_row;
              r_rd_addr  <= w_next_row;
            end else begin
              r_col_cnt <= r_col_cnt + DIM_W'(1);
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // The tagged last word is the only entry left, so its pop empties the FIFO.
          if (w_pop && w_head[0]) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdp_tile_reader.sv
// Directed bench for tdp_tile_reader with a buffer model holding mem[a] = a.
module tb_tdp_tile_reader;
  import npu_buf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nPass = 0;

  logic        cValid[$];
  logic        cReady[$];
  logic        cLast[$];
  logic        cDone[$];
  logic        cErr[$];
  logic        cBusy[$];
  logic [15:0] cAddr[$];
  logic [15:0] hsData[$];
  logic        hsLast[$];
  int          hsIdx[$];
  int          doneIdx;

  bit readyPat[11] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1};

  tdp_tile_reader_if bus();

  tdp_tile_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_rdata = bus.mem_addr;

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the falling edge just after the sampling edge.
  task automatic do_start(input logic [15:0] b, input logic [11:0] c, input logic [11:0] r,
                          input logic [11:0] s);
    bus.start      = 1'b1;
    bus.cfg_base   = b;
    bus.cfg_cols   = c;
    bus.cfg_rows   = r;
    bus.cfg_stride = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Record one sample per cycle until done is seen or the budget runs out.
  task automatic collect(input int pat, input int budget);
    cValid.delete(); cReady.delete(); cLast.delete(); cDone.delete();
    cErr.delete(); cBusy.delete(); cAddr.delete();
    hsData.delete(); hsLast.delete(); hsIdx.delete();
    doneIdx = -1;
    for (int k = 0; k < budget; k++) begin
      if (k > 0) @(negedge clk);
      bus.out_ready = (pat == 0) ? 1'b1 : readyPat[k % 11];
      #1;
      cValid.push_back(bus.out_valid);
      cReady.push_back(bus.out_ready);
      cLast.push_back(bus.out_last);
      cDone.push_back(bus.done);
      cErr.push_back(bus.err);
      cBusy.push_back(bus.busy);
      cAddr.push_back(bus.mem_addr);
      if (bus.out_valid && bus.out_ready) begin
        hsData.push_back(bus.out_data);
        hsLast.push_back(bus.out_last);
        hsIdx.push_back(k);
      end
      if (bus.done) begin
        doneIdx = k;
        break;
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done); else nPass++;
    nChecks++; if (bus.err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", bus.err); else nPass++;
    nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.out_valid); else nPass++;
    nChecks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL reset_last got %b want 0", bus.out_last); else nPass++;
    nChecks++; if (bus.out_data !== 16'h0) $display("[TB] FAIL reset_data got %h want 0", bus.out_data); else nPass++;
    nChecks++; if (bus.mem_addr !== 16'h0) $display("[TB] FAIL reset_addr got %h want 0", bus.mem_addr); else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous();
    do_start(16'd100, 12'd4, 12'd3, 12'd4);
    collect(0, 40);
    nChecks++; if (cAddr[0] !== 16'd100) $display("[TB] FAIL contig_first_addr got %0d want 100", cAddr[0]); else nPass++;
    nChecks++; if (cValid[0] !== 1'b0) $display("[TB] FAIL contig_valid_n1 got %b want 0", cValid[0]); else nPass++;
    nChecks++; if (cValid[1] !== 1'b1) $display("[TB] FAIL contig_valid_n2 got %b want 1", cValid[1]); else nPass++;
    nChecks++; if (hsData.size() != 12) $display("[TB] FAIL contig_beats got %0d want 12", hsData.size()); else nPass++;
    for (int i = 0; i < 12 && i < hsData.size(); i++) begin
      nChecks++; if (hsData[i] !== 16'(100 + i)) $display("[TB] FAIL contig_data[%0d] got %0d want %0d", i, hsData[i], 100 + i); else nPass++;
      nChecks++; if (hsLast[i] !== (i == 11)) $display("[TB] FAIL contig_last[%0d] got %b want %b", i, hsLast[i], i == 11); else nPass++;
      nChecks++; if (hsIdx[i] != i + 1) $display("[TB] FAIL contig_cycle[%0d] got %0d want %0d", i, hsIdx[i], i + 1); else nPass++;
    end
    nChecks++; if (doneIdx != 13) $display("[TB] FAIL contig_done_cycle got %0d want 13", doneIdx); else nPass++;
    nChecks++; if (cBusy[12] !== 1'b1) $display("[TB] FAIL contig_busy_before_done got %b want 1", cBusy[12]); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL contig_busy_at_done got %b want 0", bus.busy); else nPass++;
  endtask

  // Started in the done cycle of the previous tile to cover back-to-back acceptance.
  task automatic test_back_to_back_strided();
    logic [15:0] exp6 [6] = '{16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12};
    do_start(16'd0, 12'd3, 12'd2, 12'd10);
    collect(0, 40);
    nChecks++; if (cDone[0] !== 1'b0) $display("[TB] FAIL b2b_done_width got %b want 0", cDone[0]); else nPass++;
    nChecks++; if (cAddr[0] !== 16'd0) $display("[TB] FAIL b2b_first_addr got %0d want 0", cAddr[0]); else nPass++;
    nChecks++; if (hsData.size() != 6) $display("[TB] FAIL stride_beats got %0d want 6", hsData.size()); else nPass++;
    for (int i = 0; i < 6 && i < hsData.size(); i++) begin
      nChecks++; if (hsData[i] !== exp6[i]) $display("[TB] FAIL stride_data[%0d] got %0d want %0d", i, hsData[i], exp6[i]); else nPass++;
      nChecks++; if (hsLast[i] !== (i == 5)) $display("[TB] FAIL stride_last[%0d] got %b want %b", i, hsLast[i], i == 5); else nPass++;
    end
    nChecks++; if (doneIdx != 7) $display("[TB] FAIL stride_done_cycle got %0d want 7", doneIdx); else nPass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp6 [6] = '{16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12};
    int   occ = 0;
    int   issued = 0;
    int   popped = 0;
    int   lastPop = -1;
    logic expValid, pop, issue;
    do_start(16'd0, 12'd3, 12'd2, 12'd10);
    collect(1, 200);
    for (int i = 0; i < cValid.size(); i++) begin
      expValid = (occ != 0);
      nChecks++; if (cValid[i] !== expValid) $display("[TB] FAIL bp_valid[%0d] got %b want %b", i, cValid[i], expValid); else nPass++;
      if (issued < 6) begin
        nChecks++; if (cAddr[i] !== exp6[issued]) $display("[TB] FAIL bp_addr[%0d] got %0d want %0d", i, cAddr[i], exp6[issued]); else nPass++;
      end
      pop   = expValid && cReady[i];
      issue = (issued < 6) && ((occ < 2) || pop);
      if (pop) begin
        popped++;
        if (popped == 6) lastPop = i;
      end
      occ    = occ + int'(issue) - int'(pop);
      issued = issued + int'(issue);
    end
    nChecks++; if (hsData.size() != 6) $display("[TB] FAIL bp_beats got %0d want 6", hsData.size()); else nPass++;
    for (int i = 0; i < 6 && i < hsData.size(); i++) begin
      nChecks++; if (hsData[i] !== exp6[i]) $display("[TB] FAIL bp_data[%0d] got %0d want %0d", i, hsData[i], exp6[i]); else nPass++;
    end
    nChecks++; if (doneIdx < 0 || doneIdx != lastPop + 1) $display("[TB] FAIL bp_done_cycle got %0d want %0d", doneIdx, lastPop + 1); else nPass++;
  endtask

  task automatic test_rejects();
    logic [15:0] vBase [3] = '{16'd0, 16'd0, 16'd20470};
    logic [11:0] vCols [3] = '{12'd0, 12'd4, 12'd16};
    logic [11:0] vRows [3] = '{12'd1, 12'd0, 12'd1};
    @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      do_start(vBase[v], vCols[v], vRows[v], 12'd0);
      #1;
      nChecks++; if (bus.err !== 1'b1) $display("[TB] FAIL rej%0d_err got %b want 1", v, bus.err); else nPass++;
      nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rej%0d_busy got %b want 0", v, bus.busy); else nPass++;
      @(negedge clk);
      #1;
      nChecks++; if (bus.err !== 1'b0) $display("[TB] FAIL rej%0d_err_pulse got %b want 0", v, bus.err); else nPass++;
      nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rej%0d_valid got %b want 0", v, bus.out_valid); else nPass++;
      nChecks++; if (bus.mem_addr !== 16'd0) $display("[TB] FAIL rej%0d_addr got %0d want 0", v, bus.mem_addr); else nPass++;
      @(negedge clk);
    end
  endtask

  task automatic test_boundary();
    int errs = 0;
    do_start(16'd20476, 12'd4, 12'd1, 12'd0);
    collect(0, 40);
    foreach (cErr[i]) if (cErr[i] !== 1'b0) errs++;
    nChecks++; if (errs != 0) $display("[TB] FAIL bound_err got %0d pulses want 0", errs); else nPass++;
    nChecks++; if (hsData.size() != 4) $display("[TB] FAIL bound_beats got %0d want 4", hsData.size()); else nPass++;
    for (int i = 0; i < 4 && i < hsData.size(); i++) begin
      nChecks++; if (hsData[i] !== 16'(20476 + i)) $display("[TB] FAIL bound_data[%0d] got %0d want %0d", i, hsData[i], 20476 + i); else nPass++;
      nChecks++; if (hsLast[i] !== (i == 3)) $display("[TB] FAIL bound_last[%0d] got %b want %b", i, hsLast[i], i == 3); else nPass++;
    end
    nChecks++; if (doneIdx != 5) $display("[TB] FAIL bound_done_cycle got %0d want 5", doneIdx); else nPass++;
  endtask

  task automatic test_busy_start_and_reset();
    logic [15:0] got[$];
    int errs = 0;
    do_start(16'd200, 12'd4, 12'd3, 12'd4);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      bus.out_ready = 1'b1;
      bus.start     = (k == 2);
      if (k == 2) bus.cfg_cols = 12'd0;
      #1;
      if (bus.err !== 1'b0) errs++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    nChecks++; if (errs != 0) $display("[TB] FAIL busy_start_err got %0d pulses want 0", errs); else nPass++;
    nChecks++; if (got.size() != 5) $display("[TB] FAIL pre_reset_beats got %0d want 5", got.size()); else nPass++;
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      nChecks++; if (got[i] !== 16'(200 + i)) $display("[TB] FAIL pre_reset_data[%0d] got %0d want %0d", i, got[i], 200 + i); else nPass++;
    end
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.done !== 1'b0) $display("[TB] FAIL midrst_done got %b want 0", bus.done); else nPass++;
    nChecks++; if (bus.err !== 1'b0) $display("[TB] FAIL midrst_err got %b want 0", bus.err); else nPass++;
    nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_valid got %b want 0", bus.out_valid); else nPass++;
    nChecks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL midrst_last got %b want 0", bus.out_last); else nPass++;
    nChecks++; if (bus.out_data !== 16'h0) $display("[TB] FAIL midrst_data got %h want 0", bus.out_data); else nPass++;
    nChecks++; if (bus.mem_addr !== 16'h0) $display("[TB] FAIL midrst_addr got %h want 0", bus.mem_addr); else nPass++;
    rst_n = 1'b1;
    do_start(16'd300, 12'd2, 12'd1, 12'd0);
    collect(0, 40);
    nChecks++; if (cAddr[0] !== 16'd300) $display("[TB] FAIL fresh_first_addr got %0d want 300", cAddr[0]); else nPass++;
    nChecks++; if (hsData.size() != 2) $display("[TB] FAIL fresh_beats got %0d want 2", hsData.size()); else nPass++;
    for (int i = 0; i < 2 && i < hsData.size(); i++) begin
      nChecks++; if (hsData[i] !== 16'(300 + i)) $display("[TB] FAIL fresh_data[%0d] got %0d want %0d", i, hsData[i], 300 + i); else nPass++;
      nChecks++; if (hsLast[i] !== (i == 1)) $display("[TB] FAIL fresh_last[%0d] got %b want %b", i, hsLast[i], i == 1); else nPass++;
    end
    nChecks++; if (doneIdx != 3) $display("[TB] FAIL fresh_done_cycle got %0d want 3", doneIdx); else nPass++;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.cfg_base   = '0;
    bus.cfg_cols   = '0;
    bus.cfg_rows   = '0;
    bus.cfg_stride = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    $display("[TB] contiguous tile");
    test_contiguous();
    $display("[TB] back-to-back strided tile");
    test_back_to_back_strided();
    $display("[TB] backpressure");
    test_backpressure();
    $display("[TB] rejected starts");
    test_rejects();
    $display("[TB] boundary accept");
    test_boundary();
    $display("[TB] start while busy and reset mid-tile");
    test_busy_start_and_reset();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d checks", nChecks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
